// File: rtl/ball_control.sv
// rtl/ball_control.sv - Pong ball engine: motion, bounces, misses, scores and ball pixel
`timescale 1ns/1ps

module ball_control #(
  parameter int BALL_SPEED    = 100,
  parameter int PADDLE_HEIGHT = 6,
  parameter int LEFT_X        = 2,
  parameter int RIGHT_X       = 60,
  parameter int Y_MIN         = 6,
  parameter int Y_MAX         = 28,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 63,
  parameter int CENTER_X      = 31,
  parameter int CENTER_Y      = 16,
  parameter int SCORE_HOLD    = 8,
  parameter int WIN_SCORE     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serve,
  input  logic [5:0] left_paddle_y,
  input  logic [5:0] right_paddle_y,
  input  logic [5:0] counter_x,
  input  logic [5:0] counter_y,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic       draw_ball,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       point_pulse,
  output logic       game_over
);

  localparam int TW = (BALL_SPEED > 0) ? $clog2(BALL_SPEED + 1) : 1;
  localparam int HW = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SCORE,
    S_OVER
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  logic            serve_q;
  logic            serve_rise;
  logic [5:0]      ball_x_q, ball_x_d;
  logic [5:0]      ball_y_q, ball_y_d;
  logic            dir_x_q, dir_x_d;   // 1 = moving right
  logic            dir_y_q, dir_y_d;   // 1 = moving down
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;
  logic            point_q, point_d;
  logic            draw_q;

  // One-tick motion candidate, used only when the FSM is in MOVE
  logic [5:0]      step_x, step_y;
  logic            step_dx, step_dy;
  logic            miss_left, miss_right;

  // 7-bit views so paddle/ball range tests cannot wrap at the 64-row edge
  logic [6:0]      ball_x_w, ball_y_w, cx_w, cy_w, lpy_w, rpy_w;
  logic            left_zone, right_zone, draw_hit;

  assign tick       = (tick_cnt_q == TW'(BALL_SPEED));
  assign serve_rise = serve & ~serve_q;

  assign ball_x_w = {1'b0, ball_x_q};
  assign ball_y_w = {1'b0, ball_y_q};
  assign cx_w     = {1'b0, counter_x};
  assign cy_w     = {1'b0, counter_y};
  assign lpy_w    = {1'b0, left_paddle_y};
  assign rpy_w    = {1'b0, right_paddle_y};

  assign left_zone  = (ball_y_w + 7'd1 >= lpy_w) &&
                      (ball_y_w <= lpy_w + 7'(PADDLE_HEIGHT));
  assign right_zone = (ball_y_w + 7'd1 >= rpy_w) &&
                      (ball_y_w <= rpy_w + 7'(PADDLE_HEIGHT));

  assign draw_hit = (cx_w >= ball_x_w) && (cx_w <= ball_x_w + 7'd1) &&
                    (cy_w >= ball_y_w) && (cy_w <= ball_y_w + 7'd1);

  // Free-running step tick, independent of the game state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Serve delayed one clk for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_q <= 1'b0;
    end else begin
      serve_q <= serve;
    end
  end

  // Candidate next position: walls and paddles evaluated independently per axis
  always_comb begin
    step_x     = ball_x_q;
    step_y     = ball_y_q;
    step_dx    = dir_x_q;
    step_dy    = dir_y_q;
    miss_left  = 1'b0;
    miss_right = 1'b0;

    if (dir_y_q) begin
      if (ball_y_q + 6'd1 == 6'(Y_MAX)) begin
        step_dy = 1'b0;
        step_y  = ball_y_q - 6'd1;
      end else begin
        step_y  = ball_y_q + 6'd1;
      end
    end else begin
      if (ball_y_q == 6'(Y_MIN)) begin
        step_dy = 1'b1;
        step_y  = ball_y_q + 6'd1;
      end else begin
        step_y  = ball_y_q - 6'd1;
      end
    end

    if (!dir_x_q) begin
      if ((ball_x_q == 6'(LEFT_X + 2)) && left_zone) begin
        step_dx = 1'b1;
        step_x  = ball_x_q + 6'd1;
      end else if (ball_x_q == 6'(X_MIN)) begin
        miss_left = 1'b1;
      end else begin
        step_x  = ball_x_q - 6'd1;
      end
    end else begin
      if ((ball_x_q == 6'(RIGHT_X - 2)) && right_zone) begin
        step_dx = 1'b0;
        step_x  = ball_x_q - 6'd1;
      end else if (ball_x_q + 6'd1 == 6'(X_MAX)) begin
        miss_right = 1'b1;
      end else begin
        step_x  = ball_x_q + 6'd1;
      end
    end
  end

  // Game FSM next-state: serve, move, score hold, game over
  always_comb begin
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    hold_cnt_d = hold_cnt_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    point_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ball_x_d = 6'(CENTER_X);
        ball_y_d = 6'(CENTER_Y);
        if (serve_rise) begin
          state_d = S_MOVE;
        end
      end

      S_MOVE: begin
        if (tick) begin
          if (miss_left || miss_right) begin
            // Ball stays where it missed so the loss is visible during the hold
            state_d    = S_SCORE;
            hold_cnt_d = '0;
            point_d    = 1'b1;
            if (miss_left && (score_r_q < 4'(WIN_SCORE))) begin
              score_r_d = score_r_q + 4'd1;
            end
            if (miss_right && (score_l_q < 4'(WIN_SCORE))) begin
              score_l_d = score_l_q + 4'd1;
            end
          end else begin
            ball_x_d = step_x;
            ball_y_d = step_y;
            dir_x_d  = step_dx;
            dir_y_d  = step_dy;
          end
        end
      end

      S_SCORE: begin
        if (tick) begin
          if (hold_cnt_q == HW'(SCORE_HOLD - 1)) begin
            if ((score_l_q == 4'(WIN_SCORE)) || (score_r_q == 4'(WIN_SCORE))) begin
              state_d = S_OVER;
            end else begin
              // dir_x still points at the side that conceded, so the next
              // serve travels toward that player
              ball_x_d = 6'(CENTER_X);
              ball_y_d = 6'(CENTER_Y);
              dir_y_d  = 1'b1;
              state_d  = S_IDLE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end

      S_OVER: begin
        if (serve_rise) begin
          score_l_d = '0;
          score_r_d = '0;
          ball_x_d  = 6'(CENTER_X);
          ball_y_d  = 6'(CENTER_Y);
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Game state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ball_x_q   <= 6'(CENTER_X);
      ball_y_q   <= 6'(CENTER_Y);
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      hold_cnt_q <= '0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      point_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      hold_cnt_q <= hold_cnt_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      point_q    <= point_d;
    end
  end

  // Ball pixel flag, one clk behind the scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_q <= 1'b0;
    end else begin
      draw_q <= draw_hit;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign draw_ball   = draw_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign point_pulse = point_q;
  assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_ball_control.sv
// tb/tb_ball_control.sv - directed vector bench for ball_control
`timescale 1ns/1ps

module tb_ball_control;

  localparam int SPEED = 9;
  localparam int P     = SPEED + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       serve;
  logic [5:0] left_paddle_y, right_paddle_y;
  logic [5:0] counter_x, counter_y;
  logic [5:0] ball_x, ball_y;
  logic       draw_ball;
  logic [3:0] score_left, score_right;
  logic       point_pulse, game_over;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int ticks;
    bit serve;
    int lpy;
    int rpy;
    int ex;
    int ey;
    int esl;
    int esr;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  ball_control #(.BALL_SPEED(SPEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .serve          (serve),
    .left_paddle_y  (left_paddle_y),
    .right_paddle_y (right_paddle_y),
    .counter_x      (counter_x),
    .counter_y      (counter_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .draw_ball      (draw_ball),
    .score_left     (score_left),
    .score_right    (score_right),
    .point_pulse    (point_pulse),
    .game_over      (game_over)
  );

  function automatic vec_t mk(int t, bit s, int lpy, int rpy, int ex, int ey, int esl, int esr);
    vec_t v;
    v.ticks = t; v.serve = s; v.lpy = lpy; v.rpy = rpy;
    v.ex = ex; v.ey = ey; v.esl = esl; v.esr = esr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick_step(input int n);
    repeat (n) begin
      do clk1(); while (cyc % P != 0);
    end
  endtask

  task automatic press_serve();
    serve = 1'b1;
    clk1();
    serve = 1'b0;
    clk1();
  endtask

  task automatic chk_ball(input string name, input int ex, input int ey);
    chk({name, ".x"}, ball_x, ex);
    chk({name, ".y"}, ball_y, ey);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      left_paddle_y  = 6'(vecs[i].lpy);
      right_paddle_y = 6'(vecs[i].rpy);
      if (vecs[i].serve) press_serve();
      tick_step(vecs[i].ticks);
      chk_ball($sformatf("v%0d.ball", i), vecs[i].ex, vecs[i].ey);
      chk($sformatf("v%0d.score_left", i), score_left, vecs[i].esl);
      chk($sformatf("v%0d.score_right", i), score_right, vecs[i].esr);
    end
  endtask

  initial begin
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    // Rally 1: right paddle returns, left paddle out of reach -> left miss
    vecs[0]  = mk(1,  1, 20, 8, 32, 17, 0, 0);
    vecs[1]  = mk(10, 0, 20, 8, 42, 27, 0, 0);
    vecs[2]  = mk(1,  0, 20, 8, 43, 26, 0, 0);
    vecs[3]  = mk(15, 0, 20, 8, 58, 11, 0, 0);
    vecs[4]  = mk(1,  0, 20, 8, 57, 10, 0, 0);
    vecs[5]  = mk(4,  0, 20, 8, 53, 6,  0, 0);
    vecs[6]  = mk(1,  0, 20, 8, 52, 7,  0, 0);
    vecs[7]  = mk(48, 0, 20, 8, 4,  13, 0, 0);
    vecs[8]  = mk(1,  0, 20, 8, 3,  14, 0, 0);
    vecs[9]  = mk(3,  0, 20, 8, 0,  17, 0, 0);
    // Rally 2: serve goes left, left paddle returns
    vecs[10] = mk(1,  1, 20, 8, 30, 17, 0, 1);
    vecs[11] = mk(10, 0, 20, 8, 20, 27, 0, 1);
    vecs[12] = mk(1,  0, 20, 8, 19, 26, 0, 1);
    vecs[13] = mk(15, 0, 20, 8, 4,  11, 0, 1);
    vecs[14] = mk(1,  0, 10, 8, 5,  10, 0, 1);
    vecs[15] = mk(7,  0, 10, 8, 12, 9,  0, 1);

    rst = 1'b1; serve = 1'b0;
    left_paddle_y = 6'd20; right_paddle_y = 6'd8;
    counter_x = 6'd0; counter_y = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_ball("reset.ball", 31, 16);
    chk("reset.score_left", score_left, 0);
    chk("reset.score_right", score_right, 0);
    chk("reset.draw_ball", draw_ball, 0);
    chk("reset.point_pulse", point_pulse, 0);
    chk("reset.game_over", game_over, 0);
    rst = 1'b0;
    cyc = 0;

    // IDLE holds the ball without a serve
    tick_step(2);
    chk_ball("idle.ball", 31, 16);

    run_vecs(0, 0);

    // Ball pixel window at (32..33, 17..18)
    counter_x = 6'd32; counter_y = 6'd17; clk1();
    chk("draw.32_17", draw_ball, 1);
    counter_x = 6'd33; counter_y = 6'd18; clk1();
    chk("draw.33_18", draw_ball, 1);
    counter_x = 6'd34; counter_y = 6'd17; clk1();
    chk("draw.34_17", draw_ball, 0);
    counter_x = 6'd32; counter_y = 6'd19; clk1();
    chk("draw.32_19", draw_ball, 0);
    counter_x = 6'd31; counter_y = 6'd17; clk1();
    chk("draw.31_17", draw_ball, 0);

    run_vecs(1, 9);

    // Left miss: pulse, score, frozen hold of 8 ticks, recenter
    tick_step(1);
    chk("miss1.point_pulse", point_pulse, 1);
    chk("miss1.score_right", score_right, 1);
    chk("miss1.score_left", score_left, 0);
    chk_ball("miss1.frozen", 0, 17);
    clk1();
    chk("miss1.pulse_end", point_pulse, 0);
    tick_step(3);
    press_serve();
    tick_step(4);
    chk_ball("hold7.ball", 0, 17);
    tick_step(1);
    chk_ball("hold8.center", 31, 16);

    run_vecs(10, 15);

    // Asynchronous reset mid-flight
    counter_x = 6'd12; counter_y = 6'd9; clk1();
    chk("pre_rst.draw_ball", draw_ball, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_ball("async_rst.ball", 31, 16);
    chk("async_rst.draw_ball", draw_ball, 0);
    chk("async_rst.score_right", score_right, 0);
    chk("async_rst.game_over", game_over, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    counter_x = 6'd0; counter_y = 6'd0;
    tick_step(1);

    // Nine right-side misses: left player reaches the winning score
    left_paddle_y = 6'd10; right_paddle_y = 6'd40;
    for (int r = 1; r <= 9; r++) begin
      press_serve();
      tick_step(31);
      chk_ball($sformatf("r%0d.pre_miss", r), 62, 7);
      tick_step(1);
      chk($sformatf("r%0d.score_left", r), score_left, r);
      chk($sformatf("r%0d.point_pulse", r), point_pulse, 1);
      tick_step(7);
      chk($sformatf("r%0d.hold_game_over", r), game_over, 0);
      tick_step(1);
      if (r < 9) begin
        chk_ball($sformatf("r%0d.center", r), 31, 16);
      end else begin
        chk("r9.game_over", game_over, 1);
        chk_ball("r9.frozen", 62, 7);
      end
    end

    // Restart from OVER with serve held: no auto-serve
    serve = 1'b1;
    clk1();
    chk("restart.score_left", score_left, 0);
    chk("restart.score_right", score_right, 0);
    chk("restart.game_over", game_over, 0);
    chk_ball("restart.center", 31, 16);
    tick_step(2);
    chk_ball("held_serve.ball", 31, 16);
    serve = 1'b0;
    tick_step(1);
    press_serve();
    tick_step(1);
    chk_ball("reserve.ball", 32, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
